cby_param_shadow: RTL and testbench
===================================

Name: cby_param_shadow

Overview:
- Parametrised Y-channel connection block for the eFPGA fabric, the next generation after the fixed 20-track/6-pin cby tiles.
- Passes vertical tracks straight through and drives NUM_IPIN grid input pins, each from a MUX_SIZE:1 track mux.
- Configuration is scan-chained on prog_clk into a shadow register, then committed atomically to an active register. Reprogramming therefore never glitches live routing, and the chain supports readback.

Parameters:
- CHAN_W, 20: tracks per direction.
- NUM_IPIN, 6: grid input pins driven. Pin k<NUM_IPIN/2 goes to right_grid; the rest go to left_grid.
- MUX_SIZE, 8: mux inputs per pin; even, ≥2.
- STRIDE, 6: track stride between successive mux track pairs.
- Derived:
  - SEL_W = clog2(MUX_SIZE)
  - FIELD_W = SEL_W+1
  - CFG_BITS = NUM_IPIN*FIELD_W

Ports:
- prog_clk  in  1  configuration/state clock.
- pReset_n  in  1  asynchronous reset, active-low.
- chany_bottom_in  in  CHAN_W  tracks entering from below.
- chany_top_in  in  CHAN_W  tracks entering from above.
- chany_bottom_out  out  CHAN_W  = chany_top_in (combinational).
- chany_top_out  out  CHAN_W  = chany_bottom_in (combinational).
- ccff_head  in  1  config chain serial in.
- ccff_en  in  1  shift enable.
- cfg_commit  in  1  one-cycle commit request.
- ccff_tail  out  1  config chain serial out (sr[0]).
- ipin  out  NUM_IPIN  grid pin drivers. Bit k = pin k.
- cfg_full  out  1  at least CFG_BITS bits shifted since last commit/reset.
- cfg_done  out  1  one-cycle pulse: commit accepted.
- cfg_err  out  1  one-cycle pulse: commit rejected.
- active_valid  out  1  active register holds a committed image.

Behaviour:
- Reset (pReset_n=0, async):
  - sr, active, cnt cleared.
  - State IDLE.
  - All outputs 0 except the pass-through tracks.
- Shift register sr[CFG_BITS-1:0]:
  - When ccff_en=1 and no commit this cycle: sr <= {ccff_head, sr[CFG_BITS-1:1]}.
  - ccff_tail = sr[0], registered, so chain latency through the block is CFG_BITS cycles.
- Field layout: field i = sr[i*FIELD_W +: FIELD_W].
  - MSB = en.
  - Low SEL_W bits = sel.
  - The first bit shifted in lands at sr[0], i.e. pin 0 sel LSB.
- Mux mapping for pin k, j in 0..MUX_SIZE/2-1, t = (k + j*STRIDE) mod CHAN_W:
  - input 2j = chany_bottom_in[t]
  - input 2j+1 = chany_top_in[t]
- ipin[k] (combinational from the active register):
  - = input[sel] when en=1 and sel<MUX_SIZE.
  - = 0 otherwise.
- Counter cnt: 0..CFG_BITS. Increments on each accepted shift and saturates at CFG_BITS. Shifting past saturation is legal, since bits pass through to downstream blocks.
- FSM:
  - IDLE (cnt=0) -> LOAD on first shift.
  - LOAD -> FULL when cnt reaches CFG_BITS.
  - FULL stays until commit.
  - Outputs: cfg_full=1 only in FULL.
- Commit (cfg_commit=1, sampled on prog_clk):
  - In FULL:
    - active <= sr.
    - active_valid <= 1.
    - cnt <= 0, state IDLE.
    - cfg_done pulses next cycle.
    - sr is retained for readback.
  - In IDLE/LOAD:
    - active, cnt, state unchanged.
    - cfg_err pulses next cycle.
- Simultaneous cfg_commit and ccff_en: commit wins and the shift is dropped that cycle (sr, ccff_tail unchanged).
- cfg_commit held high several cycles:
  - First cycle is evaluated.
  - Following cycles are in IDLE, so they give cfg_err.
- Reset mid-shift or mid-commit clears everything. Outputs go to 0 immediately (async); deassertion is synchronised externally.

Test Plan (CHAN_W=20, NUM_IPIN=6, MUX_SIZE=8, STRIDE=6, so CFG_BITS=24):
- Reset, drive chany_bottom_in=20'hABCDE, top_in=20'h12345 -> chany_top_out=20'hABCDE, bottom_out=20'h12345, ipin=0, active_valid=0, cfg_full=0.
- Shift 24 bits setting pin0 {en=1,sel=3} and the other pins en=0, then commit -> cfg_full=1 after the 24th shift, cfg_done pulse, active_valid=1. ipin[0] follows chany_top_in[6]; ipin[5:1]=0.
- Shift only 10 bits, then commit -> cfg_err pulse, ipin unchanged from the prior image, cfg_full=0, cnt continues from 10.
- Shift 24 new bits while routing is live -> ipin holds the old image through all shifts and switches exactly on the cycle after commit (no intermediate values).
- Shift 48 bits -> ccff_tail reproduces the first 24 input bits, delayed 24 cycles, and cfg_full stays 1. Also: cfg_commit and ccff_en together in FULL -> commit accepted, sr not shifted.
- Pin 2 {en=1,sel=7}: track t=(2+18) mod 20=0, so ipin[2] follows chany_top_in[0] (wrap). Then assert pReset_n=0 mid-shift -> ipin=0 and all flags 0 asynchronously.

Source files
------------

// File: rtl/cby_param_shadow.sv
// Parametrised Y-channel connection block: straight-through vertical tracks plus NUM_IPIN
// grid-pin muxes whose configuration is scanned into a shadow chain and committed atomically.
module cby_param_shadow #(
    parameter int CHAN_W   = 20,
    parameter int NUM_IPIN = 6,
    parameter int MUX_SIZE = 8,
    parameter int STRIDE   = 6
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic [CHAN_W-1:0]   chany_bottom_in,
    input  logic [CHAN_W-1:0]   chany_top_in,
    output logic [CHAN_W-1:0]   chany_bottom_out,
    output logic [CHAN_W-1:0]   chany_top_out,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic [NUM_IPIN-1:0] ipin,
    output logic                cfg_full,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                active_valid
);

    localparam int SEL_W    = $clog2(MUX_SIZE);
    localparam int FIELD_W  = SEL_W + 1;
    localparam int CFG_BITS = NUM_IPIN * FIELD_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam int MUX_PAD  = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    // Handshake: ccff_head is taken on every prog_clk edge where ccff_en=1 and cfg_commit=0;
    // cfg_commit is a one-cycle request answered by exactly one of cfg_done/cfg_err a cycle later.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [CFG_BITS-1:0]   sr;
    logic [CFG_BITS-1:0]   active;
    logic                  shift_acc;
    logic                  commit_ok;

    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;
    assign ccff_tail        = sr[0];

    assign shift_acc = ccff_en && !cfg_commit;
    assign commit_ok = cfg_commit && (state == FULL);
    assign cfg_full  = (state == FULL);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE, LOAD: begin
                if (shift_acc) begin
                    cnt_next   = cnt + CNT_W'(1);
                    state_next = (cnt_next == CNT_MAX) ? FULL : LOAD;
                end
            end
            FULL: begin
                // Shifts while full only feed downstream blocks; the count stays saturated.
                if (cfg_commit) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sr           <= '0;
            active       <= '0;
            active_valid <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            cfg_done <= commit_ok;
            cfg_err  <= cfg_commit && (state != FULL);
            if (shift_acc) begin
                sr <= {ccff_head, sr[CFG_BITS-1:1]};
            end
            if (commit_ok) begin
                active       <= sr;
                active_valid <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
        logic [MUX_PAD-1:0] mux_in;
        logic [SEL_W-1:0]   pin_sel;
        logic               pin_en;

        assign pin_sel = active[k*FIELD_W +: SEL_W];
        assign pin_en  = active[k*FIELD_W + SEL_W];

        // Even inputs come from below, odd from above, on the same strided track.
        for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_in
            localparam int TRK = (k + j * STRIDE) % CHAN_W;
            assign mux_in[2*j]   = chany_bottom_in[TRK];
            assign mux_in[2*j+1] = chany_top_in[TRK];
        end

        if (MUX_PAD > MUX_SIZE) begin : g_pad
            assign mux_in[MUX_PAD-1:MUX_SIZE] = '0;
        end

        assign ipin[k] = (pin_en && (32'(pin_sel) < MUX_SIZE)) ? mux_in[pin_sel] : 1'b0;
    end

endmodule

// File: tb/tb_cby_param_shadow.sv
// Bench for cby_param_shadow: a table of committed images with hand-derived pin values,
// directed multi-cycle sequences and a randomized run against a bit-queue reference model.
module tb_cby_param_shadow;

    localparam int CHAN_W   = 20;
    localparam int NUM_IPIN = 6;
    localparam int MUX_SIZE = 8;
    localparam int STRIDE   = 6;
    localparam int FIELD_W  = 4;
    localparam int CFG_BITS = NUM_IPIN * FIELD_W;

    logic                prog_clk;
    logic                pReset_n;
    logic [CHAN_W-1:0]   chany_bottom_in;
    logic [CHAN_W-1:0]   chany_top_in;
    logic [CHAN_W-1:0]   chany_bottom_out;
    logic [CHAN_W-1:0]   chany_top_out;
    logic                ccff_head;
    logic                ccff_en;
    logic                cfg_commit;
    logic                ccff_tail;
    logic [NUM_IPIN-1:0] ipin;
    logic                cfg_full;
    logic                cfg_done;
    logic                cfg_err;
    logic                active_valid;

    cby_param_shadow #(
        .CHAN_W(CHAN_W), .NUM_IPIN(NUM_IPIN), .MUX_SIZE(MUX_SIZE), .STRIDE(STRIDE)
    ) dut (
        .prog_clk(prog_clk),
        .pReset_n(pReset_n),
        .chany_bottom_in(chany_bottom_in),
        .chany_top_in(chany_top_in),
        .chany_bottom_out(chany_bottom_out),
        .chany_top_out(chany_top_out),
        .ccff_head(ccff_head),
        .ccff_en(ccff_en),
        .cfg_commit(cfg_commit),
        .ccff_tail(ccff_tail),
        .ipin(ipin),
        .cfg_full(cfg_full),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err),
        .active_valid(active_valid)
    );

    // Clock and reset
    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the chain is a queue of bits (front = sr[0]), the count is unbounded.
    logic                chain[$];
    int                  n_shift;
    logic [CFG_BITS-1:0] active_m;
    logic                valid_m;
    logic                done_m;
    logic                err_m;

    typedef struct {
        logic [CFG_BITS-1:0] img;
        logic [CHAN_W-1:0]   bot;
        logic [CHAN_W-1:0]   top;
        logic [NUM_IPIN-1:0] exp_ipin;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_IPIN-1:0] model_ipin(input logic [CFG_BITS-1:0] img,
                                                         input logic [CHAN_W-1:0] b,
                                                         input logic [CHAN_W-1:0] t);
        logic [NUM_IPIN-1:0] r;
        logic [CFG_BITS-1:0] v;
        logic [CHAN_W-1:0]   b_sh;
        logic [CHAN_W-1:0]   t_sh;
        logic [3:0]          f;
        int                  sel;
        int                  trk;
        r = '0;
        v = img;
        for (int k = 0; k < NUM_IPIN; k++) begin
            f   = v[3:0];
            v   = v >> FIELD_W;
            sel = int'(f[2:0]);
            if (f[3] && sel < MUX_SIZE) begin
                trk  = (k + (sel / 2) * STRIDE) % CHAN_W;
                b_sh = b >> trk;
                t_sh = t >> trk;
                r    = r | (NUM_IPIN'((sel % 2 == 1) ? t_sh[0] : b_sh[0]) << k);
            end
        end
        return r;
    endfunction

    function automatic logic [CFG_BITS-1:0] chain_vec();
        logic [CFG_BITS-1:0] v;
        v = '0;
        foreach (chain[i]) v = v | (CFG_BITS'(chain[i]) << i);
        return v;
    endfunction

    task automatic model_reset();
        chain = {};
        repeat (CFG_BITS) chain.push_back(1'b0);
        n_shift  = 0;
        active_m = '0;
        valid_m  = 1'b0;
        done_m   = 1'b0;
        err_m    = 1'b0;
    endtask

    task automatic model_step(input logic head, input logic en, input logic commit);
        done_m = 1'b0;
        err_m  = 1'b0;
        if (commit) begin
            if (n_shift >= CFG_BITS) begin
                active_m = chain_vec();
                valid_m  = 1'b1;
                n_shift  = 0;
                done_m   = 1'b1;
            end else begin
                err_m = 1'b1;
            end
        end else if (en) begin
            chain.push_back(head);
            void'(chain.pop_front());
            n_shift++;
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic check_all();
        check("m_top_out", 32'(chany_top_out), 32'(chany_bottom_in));
        check("m_bottom_out", 32'(chany_bottom_out), 32'(chany_top_in));
        check("m_tail", 32'(ccff_tail), 32'(chain[0]));
        check("m_full", 32'(cfg_full), 32'(n_shift >= CFG_BITS));
        check("m_done", 32'(cfg_done), 32'(done_m));
        check("m_err", 32'(cfg_err), 32'(err_m));
        check("m_valid", 32'(active_valid), 32'(valid_m));
        check("m_ipin", 32'(ipin), 32'(model_ipin(active_m, chany_bottom_in, chany_top_in)));
    endtask

    // Driver: one prog_clk cycle with the given chain inputs, then compare against the model.
    task automatic cycle(input logic head, input logic en, input logic commit);
        ccff_head  = head;
        ccff_en    = en;
        cfg_commit = commit;
        model_step(head, en, commit);
        tick();
        check_all();
    endtask

    task automatic load_image(input logic [CFG_BITS-1:0] img);
        logic [CFG_BITS-1:0] v;
        v = img;
        for (int i = 0; i < CFG_BITS; i++) begin
            cycle(v[0], 1'b1, 1'b0);
            v = v >> 1;
        end
    endtask

    initial begin
        logic [CFG_BITS-1:0] v;
        logic                bq[$];
        logic                b;

        // Images: pin fields are {en, sel[2:0]}, pin 0 in the low nibble.
        vecs[0] = '{24'h00000B, 20'h00000, 20'h00040, 6'h01}; // pin0 sel3 -> top[6]
        vecs[1] = '{24'h00000B, 20'hFFFFF, 20'hFFFBF, 6'h00};
        vecs[2] = '{24'h000F00, 20'h00000, 20'h00001, 6'h04}; // pin2 sel7 -> top[0]
        vecs[3] = '{24'h000F00, 20'hFFFFF, 20'hFFFFE, 6'h00};
        vecs[4] = '{24'h888888, 20'h0002A, 20'hFFFFF, 6'h2A}; // sel0 -> bottom[k]
        vecs[5] = '{24'h999999, 20'hFFFFF, 20'h00015, 6'h15}; // sel1 -> top[k]
        vecs[6] = '{24'hCCCCCC, 20'h05000, 20'h00000, 6'h05}; // sel4 -> bottom[k+12]
        vecs[7] = '{24'h777777, 20'hFFFFF, 20'hFFFFF, 6'h00}; // all disabled
        vecs[8] = '{24'hEEEEEE, 20'h80001, 20'h00000, 6'h06}; // sel6 -> bottom[(k+18)%20]

        ccff_head       = 1'b0;
        ccff_en         = 1'b0;
        cfg_commit      = 1'b0;
        chany_bottom_in = 20'hABCDE;
        chany_top_in    = 20'h12345;
        pReset_n        = 1'b0;
        model_reset();
        #1;
        check("rst_top_out", 32'(chany_top_out), 32'h000ABCDE);
        check("rst_bottom_out", 32'(chany_bottom_out), 32'h00012345);
        check("rst_ipin", 32'(ipin), 32'h0);
        check("rst_valid", 32'(active_valid), 32'h0);
        check("rst_full", 32'(cfg_full), 32'h0);
        check("rst_tail", 32'(ccff_tail), 32'h0);
        #11;
        pReset_n = 1'b1;

        // Table of committed images
        for (int r = 0; r < 9; r++) begin
            load_image(vecs[r].img);
            check("row_full", 32'(cfg_full), 32'h1);
            chany_bottom_in = vecs[r].bot;
            chany_top_in    = vecs[r].top;
            cycle(1'b0, 1'b0, 1'b1);
            check("row_done", 32'(cfg_done), 32'h1);
            check("row_valid", 32'(active_valid), 32'h1);
            check("row_ipin", 32'(ipin), 32'(vecs[r].exp_ipin));
            check("row_top_out", 32'(chany_top_out), 32'(vecs[r].bot));
        end

        // Short load rejected; the count carries on from 10
        v = vecs[0].img;
        for (int i = 0; i < 10; i++) begin
            cycle(v[0], 1'b1, 1'b0);
            v = v >> 1;
        end
        cycle(1'b0, 1'b0, 1'b1);
        check("part_err", 32'(cfg_err), 32'h1);
        check("part_done", 32'(cfg_done), 32'h0);
        check("part_full", 32'(cfg_full), 32'h0);
        check("part_ipin", 32'(ipin), 32'h06);
        for (int i = 0; i < 14; i++) begin
            cycle(v[0], 1'b1, 1'b0);
            v = v >> 1;
            if (i == 12) check("part_full13", 32'(cfg_full), 32'h0);
        end
        check("part_full14", 32'(cfg_full), 32'h1);
        cycle(1'b0, 1'b0, 1'b1);
        check("part_commit", 32'(cfg_done), 32'h1);

        // Live reprogramming: pins hold the old image until the commit edge
        chany_bottom_in = 20'h0002A;
        chany_top_in    = 20'h00040;
        v = vecs[4].img;
        for (int i = 0; i < CFG_BITS; i++) begin
            cycle(v[0], 1'b1, 1'b0);
            v = v >> 1;
            check("live_hold", 32'(ipin), 32'h01);
        end
        cycle(1'b0, 1'b0, 1'b1);
        check("live_switch", 32'(ipin), 32'h2A);

        // Commit held for three cycles
        for (int i = 0; i < CFG_BITS; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("hold_done", 32'(cfg_done), 32'h1);
        cycle(1'b0, 1'b0, 1'b1);
        check("hold_err1", 32'(cfg_err), 32'h1);
        check("hold_done1", 32'(cfg_done), 32'h0);
        cycle(1'b0, 1'b0, 1'b1);
        check("hold_err2", 32'(cfg_err), 32'h1);

        // 48-bit pass-through and commit colliding with a shift
        bq = {};
        for (int m = 1; m <= 2 * CFG_BITS; m++) begin
            b = 1'($urandom_range(0, 1));
            bq.push_back(b);
            cycle(b, 1'b1, 1'b0);
            if (m >= CFG_BITS) begin
                check("pass_tail", 32'(ccff_tail), 32'(bq[m-CFG_BITS]));
                check("pass_full", 32'(cfg_full), 32'h1);
            end
        end
        cycle(~bq[CFG_BITS], 1'b1, 1'b1);
        check("ce_done", 32'(cfg_done), 32'h1);
        check("ce_full", 32'(cfg_full), 32'h0);
        check("ce_tail", 32'(ccff_tail), 32'(bq[CFG_BITS]));

        // Track wrap on pin 2, then asynchronous reset mid-shift
        chany_bottom_in = 20'h00000;
        chany_top_in    = 20'h00001;
        load_image(vecs[2].img);
        cycle(1'b0, 1'b0, 1'b1);
        check("wrap_ipin", 32'(ipin), 32'h04);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
        #3;
        pReset_n = 1'b0;
        #1;
        check("arst_ipin", 32'(ipin), 32'h0);
        check("arst_full", 32'(cfg_full), 32'h0);
        check("arst_valid", 32'(active_valid), 32'h0);
        check("arst_done", 32'(cfg_done), 32'h0);
        check("arst_err", 32'(cfg_err), 32'h0);
        check("arst_tail", 32'(ccff_tail), 32'h0);
        check("arst_pass", 32'(chany_bottom_out), 32'h00001);
        model_reset();
        #2;
        pReset_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            chany_bottom_in = CHAN_W'($urandom());
            chany_top_in    = CHAN_W'($urandom());
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
